// File: rtl/data_mem_bridge.sv
// data_mem_bridge: multi-cycle load/store bridge between the CPU memory stage
// and an SRAM-style valid/ready data bus. It builds byte strobes and lane data
// for stores, extends load data, and stalls the core until the access ends.
module data_mem_bridge #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_memop,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_d;

    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       memop_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt;

    logic             timeout_hit;
    logic             in_req;
    logic             in_done;
    logic             wr_req;

    // Access size is carried in memop[1:0]: 00 byte, 01 half, anything else word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_strobe = 4'b0001 << off;
            2'b01:   lane_strobe = 4'b0011 << off;
            default: lane_strobe = 4'b1111;
        endcase
    endfunction

    // Replicating the store value across lanes puts it under whichever strobe is set.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   lane_wdata = {4{data[7:0]}};
            2'b01:   lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

    // Halves are always aligned here, so only off[1] picks the upper or lower half.
    function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                                input logic        is_unsigned,
                                                input logic [1:0]  off,
                                                input logic [31:0] rword);
        logic [7:0]  b;
        logic [15:0] h;
        b = rword[{off, 3'b000} +: 8];
        h = rword[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   load_extend = {{24{b[7] & ~is_unsigned}}, b};
            2'b01:   load_extend = {{16{h[15] & ~is_unsigned}}, h};
            default: load_extend = rword;
        endcase
    endfunction

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // Next-state logic; a handshake in the final allowed cycle beats the timeout.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_memop[1:0], req_addr[1:0])) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_ready) begin
                    state_d = we_q ? DONE : WAIT_R;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            WAIT_R: begin
                if (bus_rvalid || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight without a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Wait counter restarts on every state change and counts cycles spent on the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state_d != state) begin
            cnt <= '0;
        end else if (state == REQ || state == WAIT_R) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Capture the request in IDLE and build the response as the access progresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            memop_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        memop_q <= req_memop;
                        rdata_q <= '0;
                        err_q   <= is_misaligned(req_memop[1:0], req_addr[1:0]);
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        rdata_q <= load_extend(memop_q[1:0], memop_q[2], addr_q[1:0], bus_rdata);
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_req  = (state == REQ);
    assign in_done = (state == DONE);
    assign wr_req  = in_req & we_q;

    // In IDLE the stall follows the request directly so the core freezes in the
    // same cycle it presents an access; reset forces it low.
    assign stall      = (state == IDLE) ? (req_valid & rst) : (state == REQ || state == WAIT_R);

    assign bus_valid  = in_req;
    assign bus_we     = wr_req;
    assign bus_addr   = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign bus_wstrb  = wr_req ? lane_strobe(memop_q[1:0], addr_q[1:0]) : '0;
    assign bus_wdata  = wr_req ? lane_wdata(memop_q[1:0], wdata_q) : '0;

    assign resp_valid = in_done;
    assign resp_rdata = in_done ? rdata_q : '0;
    assign resp_err   = in_done & err_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: directed bench for data_mem_bridge. A timeline model
// predicts every output on every cycle of each access; a compare process
// checks the DUT against it on each falling edge.
module tb_data_mem_bridge;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 99;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_memop;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    typedef struct {
        logic        stall;
        logic        bus_valid;
        logic        bus_we;
        logic [31:0] bus_addr;
        logic [3:0]  bus_wstrb;
        logic [31:0] bus_wdata;
        logic        resp_valid;
        logic [31:0] resp_rdata;
        logic        resp_err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          bus_valid_cycles = 0;
    int          resp_count = 0;
    logic [31:0] last_rdata = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_addr  = '0;
    logic [3:0]  last_wstrb = '0;
    logic        last_err   = 1'b0;

    data_mem_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_memop  (req_memop),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Model: number of bytes moved by a memop.
    function automatic int size_bytes(input logic [2:0] memop);
        if (memop[1:0] == 2'b00) return 1;
        if (memop[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic misaligned(input logic [2:0] memop, input logic [31:0] addr);
        return (int'(addr[1:0]) % size_bytes(memop)) != 0;
    endfunction

    function automatic logic [3:0] model_strobe(input logic [2:0] memop, input logic [31:0] addr);
        int n;
        n = size_bytes(memop);
        return 4'(((1 << n) - 1) << int'(addr[1:0]));
    endfunction

    // Each byte lane carries the store byte whose index is the lane modulo the size.
    function automatic logic [31:0] model_lanes(input logic [2:0] memop, input logic [31:0] wdata);
        logic [31:0] r;
        int n;
        n = size_bytes(memop);
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = wdata[8*(i % n) +: 8];
        end
        return r;
    endfunction

    // Arithmetic extraction: take n bytes from the offset, then subtract 2^(8n) if signed and negative.
    function automatic logic [31:0] model_load(input logic [2:0] memop, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int          n;
        int          off;
        logic [63:0] span;
        logic [63:0] v;
        n = size_bytes(memop);
        if (n == 4) return rdata;
        off  = int'(addr[1:0]);
        span = 64'd1 << (8 * n);
        v    = {32'd0, rdata} >> (8 * off);
        v    = v % span;
        if (!memop[2] && v >= (span >> 1)) v = v - span;
        return v[31:0];
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.stall      = 1'b0;
        e.bus_valid  = 1'b0;
        e.bus_we     = 1'b0;
        e.bus_addr   = '0;
        e.bus_wstrb  = '0;
        e.bus_wdata  = '0;
        e.resp_valid = 1'b0;
        e.resp_rdata = '0;
        e.resp_err   = 1'b0;
        return e;
    endfunction

    // Compare every DUT output against the model on each falling edge that has an expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin : cmp
            exp_t e;
            e = exp_q.pop_front();
            check_output("stall",      32'(stall),      32'(e.stall));
            check_output("bus_valid",  32'(bus_valid),  32'(e.bus_valid));
            check_output("bus_we",     32'(bus_we),     32'(e.bus_we));
            check_output("bus_addr",   bus_addr,        e.bus_addr);
            check_output("bus_wstrb",  32'(bus_wstrb),  32'(e.bus_wstrb));
            check_output("bus_wdata",  bus_wdata,       e.bus_wdata);
            check_output("resp_valid", 32'(resp_valid), 32'(e.resp_valid));
            check_output("resp_rdata", resp_rdata,      e.resp_rdata);
            check_output("resp_err",   32'(resp_err),   32'(e.resp_err));
            if (bus_valid) begin
                bus_valid_cycles++;
                last_wstrb = bus_wstrb;
                last_wdata = bus_wdata;
                last_addr  = bus_addr;
            end
            if (resp_valid) begin
                resp_count++;
                last_rdata = resp_rdata;
                last_err   = resp_err;
            end
        end
    end

    // One access: ready_at / rvalid_at are 1-based cycle indexes within REQ / WAIT_R
    // (NEVER for no handshake); rv_on_ready adds a stray rvalid in the bus_ready cycle.
    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [2:0] memop, input int ready_at, input int rvalid_at,
                                  input logic [31:0] rdata, input logic rv_on_ready);
        int          r;
        int          w;
        int          done;
        logic        mis;
        logic        err;
        logic [31:0] rd;
        exp_t        e;
        mis = misaligned(memop, addr);
        r   = 0;
        w   = 0;
        err = mis;
        if (!mis) begin
            if (ready_at >= 1 && ready_at <= TIMEOUT) begin
                r = ready_at;
            end else begin
                r   = TIMEOUT;
                err = 1'b1;
            end
            if (!we && !err) begin
                if (rvalid_at >= 1 && rvalid_at <= TIMEOUT) begin
                    w = rvalid_at;
                end else begin
                    w   = TIMEOUT;
                    err = 1'b1;
                end
            end
        end
        done = 1 + r + w;
        rd   = (we || err) ? 32'd0 : model_load(memop, addr, rdata);
        bus_valid_cycles = 0;
        resp_count       = 0;
        for (int c = 0; c <= done + 1; c++) begin
            req_valid  = (c < done);
            req_we     = we;
            req_addr   = addr;
            req_wdata  = wdata;
            req_memop  = memop;
            bus_ready  = !mis && (c == ready_at);
            bus_rvalid = 1'b0;
            bus_rdata  = 32'hDEADBEEF;
            if (!mis && !we && rv_on_ready && c == ready_at) bus_rvalid = 1'b1;
            if (!mis && !we && c > r && c == r + rvalid_at) begin
                bus_rvalid = 1'b1;
                bus_rdata  = rdata;
            end
            e = idle_exp();
            e.stall      = (c < done);
            e.bus_valid  = !mis && c >= 1 && c <= r;
            e.bus_we     = e.bus_valid && we;
            e.bus_addr   = e.bus_valid ? (addr & ~32'h3) : 32'd0;
            e.bus_wstrb  = e.bus_we ? model_strobe(memop, addr) : 4'd0;
            e.bus_wdata  = e.bus_we ? model_lanes(memop, wdata) : 32'd0;
            e.resp_valid = (c == done);
            e.resp_rdata = (c == done) ? rd : 32'd0;
            e.resp_err   = (c == done) && err;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        req_valid  = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    // Start a load, drop reset while it waits for read data, and confirm it vanishes.
    task automatic run_reset_abort();
        exp_t e;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h7000;
        req_wdata = 32'h0;
        req_memop = 3'b010;
        bus_ready = 1'b0;
        bus_rvalid = 1'b0;
        e = idle_exp();
        e.stall = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus_ready = 1'b1;
        e = idle_exp();
        e.stall     = 1'b1;
        e.bus_valid = 1'b1;
        e.bus_addr  = 32'h7000;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus_ready = 1'b0;
        e = idle_exp();
        e.stall = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("abort_stall",      32'(stall),      32'd0);
        check_output("abort_bus_valid",  32'(bus_valid),  32'd0);
        check_output("abort_resp_valid", 32'(resp_valid), 32'd0);
        req_valid  = 1'b0;
        resp_count = 0;
        @(posedge clk);
        #1;
        exp_q.push_back(idle_exp());
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_rvalid = (i == 0);
            exp_q.push_back(idle_exp());
            @(posedge clk);
            #1;
        end
        bus_rvalid = 1'b0;
        check_output("abort_no_resp", 32'(resp_count), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_memop  = '0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;

        repeat (2) @(negedge clk);
        check_output("rst_stall",      32'(stall),      32'd0);
        check_output("rst_bus_valid",  32'(bus_valid),  32'd0);
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst_resp_rdata", resp_rdata,      32'd0);
        check_output("rst_bus_wstrb",  32'(bus_wstrb),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        check_output("pin_lh",     model_load(3'b001, 32'h2002, 32'h80011234), 32'hFFFF8001);
        check_output("pin_lhu",    model_load(3'b101, 32'h2002, 32'h80011234), 32'h00008001);
        check_output("pin_lb",     model_load(3'b000, 32'h2000, 32'h80011234), 32'h00000034);
        check_output("pin_strobe", 32'(model_strobe(3'b000, 32'h1003)),        32'h8);
        check_output("pin_lanes",  model_lanes(3'b000, 32'h000000AB),          32'hABABABAB);

        apply_stimulus(1'b1, 32'h1003, 32'h000000AB, 3'b000, 1, NEVER, 32'h0, 1'b0);
        check_output("sb_wstrb", 32'(last_wstrb), 32'h8);
        check_output("sb_wdata", last_wdata,      32'hABABABAB);
        check_output("sb_addr",  last_addr,       32'h1000);
        check_output("sb_err",   32'(last_err),   32'd0);
        check_output("sb_resps", 32'(resp_count), 32'd1);

        apply_stimulus(1'b0, 32'h2002, 32'h0, 3'b001, 1, 1, 32'h80011234, 1'b0);
        check_output("lh_data", last_rdata, 32'hFFFF8001);
        apply_stimulus(1'b0, 32'h2002, 32'h0, 3'b101, 1, 1, 32'h80011234, 1'b0);
        check_output("lhu_data", last_rdata, 32'h00008001);
        apply_stimulus(1'b0, 32'h2000, 32'h0, 3'b000, 1, 1, 32'h80011234, 1'b0);
        check_output("lb_data", last_rdata, 32'h00000034);

        apply_stimulus(1'b0, 32'h0006, 32'h0, 3'b010, 1, 1, 32'h12345678, 1'b0);
        check_output("mis_bus_cycles", 32'(bus_valid_cycles), 32'd0);
        check_output("mis_err",        32'(last_err),         32'd1);

        apply_stimulus(1'b1, 32'h3000, 32'h11223344, 3'b010, NEVER, NEVER, 32'h0, 1'b0);
        check_output("to_bus_cycles", 32'(bus_valid_cycles), 32'd16);
        check_output("to_err",        32'(last_err),         32'd1);
        apply_stimulus(1'b1, 32'h3000, 32'h11223344, 3'b010, 16, NEVER, 32'h0, 1'b0);
        check_output("rdy16_bus_cycles", 32'(bus_valid_cycles), 32'd16);
        check_output("rdy16_err",        32'(last_err),         32'd0);

        apply_stimulus(1'b0, 32'h3001, 32'h0, 3'b000, 4, 2, 32'h1234F678, 1'b1);
        check_output("slow_lb_data",  last_rdata,        32'hFFFFFFF6);
        check_output("slow_lb_resps", 32'(resp_count),   32'd1);

        apply_stimulus(1'b1, 32'h4002, 32'h0000BEEF, 3'b001, 2, NEVER, 32'h0, 1'b0);
        check_output("sh_wstrb", 32'(last_wstrb), 32'hC);
        check_output("sh_wdata", last_wdata,      32'hBEEFBEEF);

        apply_stimulus(1'b0, 32'h5000, 32'h0, 3'b010, 1, NEVER, 32'h0, 1'b0);
        check_output("rto_err",  32'(last_err), 32'd1);
        check_output("rto_data", last_rdata,    32'd0);

        apply_stimulus(1'b0, 32'h6000, 32'h0, 3'b001, 1, 16, 32'h00007FFF, 1'b0);
        check_output("rv16_data", last_rdata, 32'h00007FFF);

        run_reset_abort();
        apply_stimulus(1'b0, 32'h7000, 32'h0, 3'b010, 1, 1, 32'hCAFEF00D, 1'b0);
        check_output("post_rst_lw", last_rdata, 32'hCAFEF00D);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
